fetch_pc_unit: RTL and testbench

Parametrised program-counter and instruction-fetch front end for the RISC-V core. It generates sequential word-aligned fetch addresses and accepts branch/jump redirects. It issues requests to a synchronous 1-cycle-latency instruction memory and buffers returned {pc, instr} pairs in a DEPTH-entry FIFO. Decode drains the FIFO over a valid/ready handshake.

---
 rtl/fetch_pc_unit.sv | 100 ++++++++++
 tb/tb_fetch_pc_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and instruction-fetch front end with a decode-side FIFO
//   clk, reset        : clock and synchronous active-high reset
//   redirect_valid/pc : flush the fetch path and restart at redirect_pc (word aligned)
//   imem_req/addr     : fetch request to a 1-cycle-latency instruction memory
//   imem_rdata        : instruction returned one cycle after imem_req
//   out_valid/ready   : head of FIFO offered to decode, {out_pc, out_instr}
//   occupancy         : number of buffered entries
module fetch_pc_unit #(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_instr,
   output logic [CW-1:0]   occupancy
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
   logic            inflight_q, inflight_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] fifo_pc_q [DEPTH];
   logic [XLEN-1:0] fifo_pc_d [DEPTH];
   logic [31:0]     fifo_instr_q [DEPTH];
   logic [31:0]     fifo_instr_d [DEPTH];
   logic            push, pop;
   logic            unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Credits include the in-flight request, so the FIFO can never overflow.
   assign imem_req  = !reset && !redirect_valid &&
                      (({1'b0, count_q} + (CW + 1)'(inflight_q)) < DEPTH_C);
   assign imem_addr = fetch_pc_q;
   assign out_valid = count_q != '0;
   assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q] : '0;
   assign out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : '0;
   assign occupancy = count_q;
   assign push      = inflight_q && !redirect_valid;
   assign pop       = out_valid && out_ready;

   always_comb begin
      fifo_pc_d    = fifo_pc_q;
      fifo_instr_d = fifo_instr_q;
      if (push) begin
         fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
         fifo_instr_d[wr_ptr_q] = imem_rdata;
      end
      wr_ptr_d      = push ? ((wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
      rd_ptr_d      = pop ? ((rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
      count_d       = count_q + CW'(push) - CW'(pop);
      inflight_d    = imem_req;
      inflight_pc_d = imem_req ? fetch_pc_q : inflight_pc_q;
      fetch_pc_d    = imem_req ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
      // A redirect drops buffered and arriving instructions; a same-cycle pop is still taken.
      if (redirect_valid) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_VECTOR;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible while count is nonzero.
   always_ff @(posedge clk) begin
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
   end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;
   logic        clk, reset, redirect_valid, out_ready;
   logic [31:0] redirect_pc, imem_addr, imem_rdata, out_pc, out_instr;
   logic        imem_req, out_valid;
   logic [2:0]  occupancy;
   logic        b_req, b_out_valid;
   logic [7:0]  b_addr, b_out_pc;
   logic [31:0] b_out_instr;
   logic [2:0]  b_occ;
   int tests = 0;
   int fails = 0;

   fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .occupancy(occupancy)
   );

   fetch_pc_unit #(.XLEN(8), .RESET_VECTOR(8'hF8), .DEPTH(4)) dut_wrap (
      .clk(clk), .reset(reset), .redirect_valid(1'b0), .redirect_pc(8'h00),
      .imem_req(b_req), .imem_addr(b_addr), .imem_rdata(32'h0),
      .out_valid(b_out_valid), .out_ready(1'b1), .out_pc(b_out_pc), .out_instr(b_out_instr),
      .occupancy(b_occ)
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) imem_rdata <= mem(imem_addr);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      chk("occ_le_depth", {63'b0, occupancy <= 3'd4}, 64'd1);
   endtask

   initial begin
      logic [31:0] drain [6];
      drain = '{32'h108, 32'h10C, 32'h110, 32'h114, 32'h118, 32'h11C};
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
      repeat (2) cyc();
      cyc(); redirect_valid = 1'b1; redirect_pc = 32'h500; #1;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_instr", out_instr, 0);
      chk("rst_occ", occupancy, 0);
      // C0..C3: reset release, redirect during reset ignored
      cyc(); reset = 1'b0; redirect_valid = 1'b0; #1;
      chk("c0_req", imem_req, 1);
      chk("c0_addr", imem_addr, 32'h100);
      chk("c0_valid", out_valid, 0);
      chk("wrap_c0", b_addr, 8'hF8);
      cyc(); #1;
      chk("c1_addr", imem_addr, 32'h104);
      chk("c1_valid", out_valid, 0);
      chk("wrap_c1", b_addr, 8'hFC);
      cyc(); #1;
      chk("c2_addr", imem_addr, 32'h108);
      chk("c2_valid", out_valid, 1);
      chk("c2_pc", out_pc, 32'h100);
      chk("c2_instr", out_instr, mem(32'h100));
      chk("wrap_c2", b_addr, 8'h00);
      cyc(); #1;
      chk("c3_pc", out_pc, 32'h104);
      chk("c3_instr", out_instr, mem(32'h104));
      chk("c3_addr", imem_addr, 32'h10C);
      chk("wrap_c3", b_addr, 8'h04);
      chk("wrap_c3_req", b_req, 1);
      // C4..C13: back-pressure
      for (int i = 0; i < 10; i++) begin
         cyc(); out_ready = 1'b0; #1;
         chk("stall_head", out_pc, 32'h108);
         if (i == 0) chk("stall_addr0", imem_addr, 32'h110);
         if (i >= 2) chk("stall_req", imem_req, 0);
         if (i >= 3) chk("stall_occ", occupancy, 4);
      end
      // C14..C19: drain in order, then streaming
      for (int i = 0; i < 6; i++) begin
         cyc(); out_ready = 1'b1; #1;
         chk("drain_valid", out_valid, 1);
         chk("drain_pc", out_pc, drain[i]);
         if (i == 0) chk("drain_nobypass", imem_req, 0);
         if (i == 1) chk("drain_req_addr", imem_addr, 32'h118);
         if (i >= 1) chk("drain_req", imem_req, 1);
      end
      chk("drain_instr", out_instr, mem(32'h11C));
      // C20: build up three entries
      cyc(); out_ready = 1'b0; #1;
      chk("c20_pc", out_pc, 32'h120);
      chk("c20_addr", imem_addr, 32'h12C);
      // C21: redirect to misaligned target
      cyc(); redirect_valid = 1'b1; redirect_pc = 32'h2003; #1;
      chk("redir_occ_before", occupancy, 3);
      chk("redir_req", imem_req, 0);
      cyc(); redirect_valid = 1'b0; out_ready = 1'b1; #1;
      chk("redir_occ", occupancy, 0);
      chk("redir_valid1", out_valid, 0);
      chk("redir_addr", imem_addr, 32'h2000);
      chk("redir_req1", imem_req, 1);
      cyc(); #1;
      chk("redir_valid2", out_valid, 0);
      chk("redir_addr2", imem_addr, 32'h2004);
      cyc(); #1;
      chk("redir_pc", out_pc, 32'h2000);
      chk("redir_instr", out_instr, mem(32'h2000));
      cyc(); #1;
      chk("redir_pc2", out_pc, 32'h2004);
      // C26: redirect during a pop handshake
      cyc(); redirect_valid = 1'b1; redirect_pc = 32'h3000; #1;
      chk("hs_valid", out_valid, 1);
      chk("hs_pc", out_pc, 32'h2008);
      cyc(); redirect_valid = 1'b0; #1;
      chk("hs_valid1", out_valid, 0);
      chk("hs_addr", imem_addr, 32'h3000);
      cyc(); #1;
      chk("hs_valid2", out_valid, 0);
      cyc(); #1;
      chk("hs_pc_new", out_pc, 32'h3000);
      cyc(); #1;
      chk("hs_pc_new2", out_pc, 32'h3004);
      // C31..C33: fill credits, then reset with a response in flight
      cyc(); out_ready = 1'b0; #1;
      chk("c31_pc", out_pc, 32'h3008);
      chk("c31_addr", imem_addr, 32'h3010);
      cyc(); #1;
      chk("c32_addr", imem_addr, 32'h3014);
      chk("c32_occ", occupancy, 2);
      cyc(); reset = 1'b1; #1;
      chk("c33_occ", occupancy, 3);
      chk("c33_req", imem_req, 0);
      cyc(); reset = 1'b0; out_ready = 1'b1; #1;
      chk("rr_occ", occupancy, 0);
      chk("rr_valid", out_valid, 0);
      chk("rr_addr", imem_addr, 32'h100);
      chk("rr_wrap_addr", b_addr, 8'hF8);
      cyc(); #1;
      chk("rr_valid2", out_valid, 0);
      cyc(); #1;
      chk("rr_pc", out_pc, 32'h100);
      chk("rr_instr", out_instr, mem(32'h100));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
